// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request and response
// valid/ready handshakes plus the program-load write port.
interface imem_responder_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_inst;
    logic             rsp_err;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [WIDTH-1:0] prog_data;

    // Fetch stage / loader side
    modport master (
        output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Multi-cycle instruction ROM model answering fetch PC requests.
// One request is in flight at a time: IDLE accepts, WAIT burns the configured
// latency, RESP holds the registered instruction until the consumer takes it.
// The program-load port writes the array in any state and wins over fetch in IDLE.
module imem_responder #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH_WORDS = 256,
    parameter int               LATENCY     = 2,
    parameter logic [WIDTH-1:0] NOP_INST    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    imem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter only has to hold LATENCY-2
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0] rd_word;
    logic             rd_bad;

    // Misaligned PCs and PCs past the end of the array (no wrap) are errors
    function automatic logic is_bad_addr(input logic [WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != '0);
    endfunction

    assign bus.req_ready = (state_q == IDLE) && !bus.prog_we && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_inst  = inst_q;
    assign bus.rsp_err   = err_q;

    // With LATENCY==1 the lookup happens in the acceptance cycle, before addr_q holds the PC
    assign rd_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign rd_word = mem[rd_addr[AW+1:2]];
    assign rd_bad  = is_bad_addr(rd_addr);

    // Program-load write port; array is deliberately not reset so code survives reset
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Next-state and response capture; the read uses pre-edge contents (read-before-write)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.req_addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        err_d   = rd_bad;
                        inst_d  = rd_bad ? NOP_INST : rd_word;
                    end else begin
                        cnt_d   = CW'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = rd_bad;
                    inst_d  = rd_bad ? NOP_INST : rd_word;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a transaction-level reference model
// (shadow memory plus one pending request stamped with its acceptance cycle)
// checks the LATENCY=2 instance every cycle; directed sequences pin literal
// values; a second LATENCY=1 instance shares the load port.
module tb_imem_responder;
    localparam int LAT0 = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    imem_responder_if #(.WIDTH(32), .AW(8)) bus0 ();
    imem_responder_if #(.WIDTH(32), .AW(8)) bus1 ();

    imem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(LAT0), .NOP_INST(NOP)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    imem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1), .NOP_INST(NOP)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    assign bus1.prog_we   = bus0.prog_we;
    assign bus1.prog_addr = bus0.prog_addr;
    assign bus1.prog_data = bus0.prog_data;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [256];
    bit          pend = 1'b0;
    int          acc = 0;
    int          cyc = 0;
    logic [31:0] paddr;
    logic [31:0] exp_inst;
    logic        exp_err;

    // Compare DUT against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        bit exp_valid, exp_ready;
        if (reset) begin
            chk("rst_rsp_valid", bus0.rsp_valid, 0);
            chk("rst_rsp_inst", bus0.rsp_inst, 0);
            chk("rst_rsp_err", bus0.rsp_err, 0);
            chk("rst_req_ready", bus0.req_ready, 0);
            pend = 1'b0;
        end else begin
            exp_valid = pend && (cyc >= acc + LAT0);
            exp_ready = !pend && !bus0.prog_we;
            chk("req_ready", bus0.req_ready, exp_ready);
            chk("rsp_valid", bus0.rsp_valid, exp_valid);
            if (exp_valid) begin
                chk("rsp_inst", bus0.rsp_inst, exp_inst);
                chk("rsp_err", bus0.rsp_err, exp_err);
            end
            if (bus0.req_valid && exp_ready) begin
                pend  = 1'b1;
                acc   = cyc;
                paddr = bus0.req_addr;
            end
            // The response reflects memory as it stands just before the edge entering RESP
            if (pend && cyc == acc + LAT0 - 1) begin
                exp_err  = (paddr % 4 != 0) || (paddr >= 32'd1024);
                exp_inst = exp_err ? NOP : ref_mem[paddr / 4];
            end
            if (exp_valid && bus0.rsp_ready) pend = 1'b0;
        end
        if (bus0.prog_we) ref_mem[bus0.prog_addr] = bus0.prog_data;
        cyc++;
    end

    task automatic send(input logic [31:0] a, output time t);
        bus0.req_valid = 1'b1;
        bus0.req_addr  = a;
        t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus0.req_ready) begin
                t = $time;
                break;
            end
        end
        chk("send_accepted", (t != 0), 1);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        bus0.req_addr  = $urandom;
    endtask

    task automatic wait_rsp(output int n, output logic [31:0] inst, output logic err);
        bit found = 1'b0;
        n = 0;
        inst = 'x;
        err = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus0.rsp_valid) begin
                found = 1'b1;
                inst = bus0.rsp_inst;
                err = bus0.rsp_err;
                break;
            end
        end
        chk("rsp_arrived", found, 1);
        @(posedge clk); #1;
    endtask

    task automatic prog(input logic [7:0] a, input logic [31:0] d);
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = a;
        bus0.prog_data = d;
        @(posedge clk); #1;
        bus0.prog_we   = 1'b0;
    endtask

    initial begin
        time t1, t2;
        int n;
        logic [31:0] inst;
        logic err;

        reset = 1'b1;
        bus0.req_valid = 0; bus0.req_addr = 0; bus0.rsp_ready = 1;
        bus0.prog_we = 0; bus0.prog_addr = 0; bus0.prog_data = 0;
        bus1.req_valid = 0; bus1.req_addr = 0; bus1.rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Fill the whole image, then the known program words
        for (int i = 0; i < 256; i++) prog(8'(i), $urandom);
        prog(8'd0, 32'h00500093);
        prog(8'd1, 32'h00a00113);
        prog(8'd2, 32'h11111111);

        // LATENCY=1 instance: response one cycle after acceptance
        bus1.req_valid = 1'b1; bus1.req_addr = 32'h0;
        @(negedge clk); chk("l1_req_ready", bus1.req_ready, 1);
        @(posedge clk); #1 bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("l1_rsp_valid", bus1.rsp_valid, 1);
        chk("l1_rsp_inst", bus1.rsp_inst, 32'h00500093);
        chk("l1_rsp_err", bus1.rsp_err, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("l1_rsp_done", bus1.rsp_valid, 0);
        @(posedge clk); #1;

        // Basic fetch and request spacing
        send(32'h0, t1);
        wait_rsp(n, inst, err);
        chk("basic0_lat", n, 2);
        chk("basic0_inst", inst, 32'h00500093);
        chk("basic0_err", err, 0);
        send(32'h4, t2);
        chk("basic_spacing", 32'((t2 - t1) / 10), 3);
        wait_rsp(n, inst, err);
        chk("basic1_lat", n, 2);
        chk("basic1_inst", inst, 32'h00a00113);

        // Backpressure with a write to the word being returned
        bus0.rsp_ready = 1'b0;
        send(32'h4, t1);
        wait_rsp(n, inst, err);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus0.prog_we = 1'b1; bus0.prog_addr = 8'd1; bus0.prog_data = 32'hDEADBEEF;
            end
            bus0.req_valid = 1'b1; bus0.req_addr = 32'h8;
            @(negedge clk);
            chk("bp_valid", bus0.rsp_valid, 1);
            chk("bp_inst", bus0.rsp_inst, 32'h00a00113);
            chk("bp_ready", bus0.req_ready, 0);
            @(posedge clk); #1;
            bus0.prog_we = 1'b0;
        end
        bus0.rsp_ready = 1'b1;
        bus0.req_addr = 32'h0;
        @(negedge clk); chk("bp_hs_ready", bus0.req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_next_ready", bus0.req_ready, 1);
        @(posedge clk); #1 bus0.req_valid = 1'b0;
        wait_rsp(n, inst, err);
        chk("bp_next_inst", inst, 32'h00500093);

        // Error responses
        send(32'h2, t1);
        wait_rsp(n, inst, err);
        chk("mis_err", err, 1);
        chk("mis_inst", inst, NOP);
        send(32'h400, t1);
        wait_rsp(n, inst, err);
        chk("oor_err", err, 1);
        chk("oor_inst", inst, NOP);

        // Load has priority over fetch
        bus0.prog_we = 1'b1; bus0.prog_addr = 8'd5; bus0.prog_data = 32'h55555555;
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h0;
        @(negedge clk); chk("prio_ready", bus0.req_ready, 0);
        @(posedge clk); #1 bus0.prog_we = 1'b0; bus0.req_valid = 1'b0;
        @(negedge clk); chk("prio_no_rsp", bus0.rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("prio_no_rsp2", bus0.rsp_valid, 0);
        @(posedge clk); #1;

        // Write on the edge entering RESP is not seen; a re-fetch sees it
        send(32'h8, t1);
        bus0.prog_we = 1'b1; bus0.prog_addr = 8'd2; bus0.prog_data = 32'h22222222;
        @(posedge clk); #1 bus0.prog_we = 1'b0;
        wait_rsp(n, inst, err);
        chk("rbw_old", inst, 32'h11111111);
        send(32'h8, t1);
        wait_rsp(n, inst, err);
        chk("rbw_new", inst, 32'h22222222);

        // Asynchronous reset while in WAIT
        send(32'h0, t1);
        #3 reset = 1'b1;
        #1;
        chk("ares_valid", bus0.rsp_valid, 0);
        chk("ares_inst", bus0.rsp_inst, 0);
        chk("ares_err", bus0.rsp_err, 0);
        chk("ares_ready", bus0.req_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); chk("ares_no_rsp", bus0.rsp_valid, 0);
        end
        @(posedge clk); #1;
        send(32'h4, t1);
        wait_rsp(n, inst, err);
        chk("ares_mem1", inst, 32'hDEADBEEF);
        send(32'h0, t1);
        wait_rsp(n, inst, err);
        chk("ares_mem0", inst, 32'h00500093);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus0.req_valid = ($urandom % 2) == 0;
            case ($urandom % 8)
                5:       bus0.req_addr = {22'd0, 8'($urandom), 2'($urandom % 3 + 1)};
                6:       bus0.req_addr = 32'h400 + ($urandom % 4096);
                7:       bus0.req_addr = $urandom;
                default: bus0.req_addr = {22'd0, 8'($urandom), 2'b00};
            endcase
            bus0.rsp_ready = ($urandom % 10) < 7;
            bus0.prog_we   = ($urandom % 7) == 0;
            bus0.prog_addr = 8'($urandom);
            bus0.prog_data = $urandom;
            @(posedge clk); #1;
        end
        bus0.req_valid = 1'b0; bus0.prog_we = 1'b0; bus0.rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that serves the fetch stage's PC requests over a valid/ready request and response handshake.
- Models a multi-cycle instruction ROM with configurable latency.
- Includes a program-load write port, used by bench and boot logic to fill the code image before or between fetches.
- Sits between the fetch PC register and the decode stage; replaces the zero-latency combinational instruction lookup.

Parameters:
- WIDTH, 32, instruction and address width in bits.
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, minimum 2.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; minimum 1.
- NOP_INST, 32'h00000013, instruction returned on an error response (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  WIDTH  byte address (PC) of the requested instruction.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response this cycle.
- rsp_inst  output  WIDTH  fetched instruction.
- rsp_err  output  1  request was misaligned or out of range.
- prog_we  input  1  program-load write enable.
- prog_addr  input  clog2(DEPTH_WORDS)  word index to write.
- prog_data  input  WIDTH  word to write.

Behaviour:
- Reset values (asynchronous, effective immediately): state=IDLE, req_ready=0 while reset is high, rsp_valid=0, rsp_inst=0, rsp_err=0, latency counter=0, captured address=0.
- Memory array is not reset; contents survive reset.
- FSM states:
  - IDLE: req_ready = !prog_we. Acceptance = req_valid && req_ready.
    - On acceptance: capture req_addr.
    - If LATENCY==1, go to RESP on the next edge.
    - Otherwise load counter=LATENCY-2 and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle. When counter==0, go to RESP on the next edge.
  - RESP: rsp_valid=1, req_ready=0. rsp_inst and rsp_err stay stable until rsp_ready=1. On rsp_valid && rsp_ready, go to IDLE next edge. No new request is accepted in the handshake cycle.
- Latency: acceptance at edge N gives rsp_valid high from edge N+LATENCY.
  - Minimum request-to-request spacing is LATENCY+1 cycles with rsp_ready held high.
- Read sampling: rsp_inst and rsp_err are registered on the edge that enters RESP.
  - Word index = captured_addr[clog2(DEPTH_WORDS)+1:2].
- Error rule: rsp_err=1 and rsp_inst=NOP_INST if either condition holds:
  - captured_addr[1:0] != 0;
  - captured_addr >= 4*DEPTH_WORDS (upper bits nonzero).
  - Otherwise rsp_err=0 and rsp_inst = mem[word index].
- Program writes:
  - prog_we writes mem[prog_addr]=prog_data on the clock edge, in any state.
  - In IDLE, prog_we deasserts req_ready (load has priority over fetch).
  - Write-vs-read ordering: a write on the same edge that enters RESP is NOT visible in that response (read-before-write). Writes on earlier edges are visible.
- Backpressure: an indefinite rsp_ready=0 holds RESP with outputs frozen. prog_we during this hold does not alter rsp_inst.
- Reset mid-operation (WAIT or RESP): the transaction is dropped, outputs return to reset values, and no response is produced after reset releases.
- Address wrap: no wrap-around. Addresses beyond the array always give the error response.
- req_addr is ignored whenever req_ready=0.

Test Plan:
- Basic fetch, LATENCY=2:
  - Stimulus: prog_we writes mem[0]=32'h00500093, mem[1]=32'h00a00113; request addr 0, then addr 4, rsp_ready=1.
  - Required: rsp_valid exactly 2 cycles after each acceptance with inst 32'h00500093 then 32'h00a00113, rsp_err=0; requests spaced 3 cycles apart.
- Backpressure:
  - Stimulus: request addr 4, hold rsp_ready=0 for 5 cycles, write mem[1]=32'hDEADBEEF during the hold.
  - Required: rsp_valid stays high with rsp_inst=32'h00a00113 throughout; req_ready=0; response accepted when rsp_ready rises; a new request only in the following cycle.
- Errors:
  - Stimulus: request addr 32'h00000002, then addr 32'h00000400 (DEPTH_WORDS=256).
  - Required: both responses give rsp_err=1 and rsp_inst=32'h00000013.
- Load priority and ordering:
  - Stimulus: assert prog_we and req_valid together in IDLE.
  - Required: req_ready=0 and no acceptance.
  - Stimulus: write mem[2] on the edge entering RESP for a request to addr 8.
  - Required: the old mem[2] value is returned; a re-fetch of addr 8 returns the new value.
- Reset mid-transaction:
  - Stimulus: assert reset asynchronously (between clock edges) while in WAIT.
  - Required: rsp_valid=0 and rsp_inst=0 immediately; no response after release; previously loaded mem contents still read correctly.
- LATENCY=1 build:
  - Stimulus: request addr 0.
  - Required: rsp_valid one cycle after acceptance with the correct data.
